// File: rtl/trailing_zeros_expander_if.sv
// Bundle of the count input handshake plus the serial and parallel result outputs
// of the trailing-zeros expander.
interface trailing_zeros_expander_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int DIN_W = $clog2(DATA_WIDTH) + 1;

    logic [DIN_W-1:0]      din;
    logic                  din_valid;
    logic                  din_ready;
    logic                  bit_out;
    logic                  bit_valid;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  err;

    modport master (
        output din, din_valid,
        input  din_ready, bit_out, bit_valid, dout, dout_valid, err
    );

    modport slave (
        input  din, din_valid,
        output din_ready, bit_out, bit_valid, dout, dout_valid, err
    );
endinterface

// File: rtl/trailing_zeros_expander.sv
// Expands a trailing-zero count into a serial LSB-first bit stream and the
// one-hot word it describes (all zeros when the count reaches DATA_WIDTH).
module trailing_zeros_expander #(
    parameter int DATA_WIDTH = 32
) (
    input logic                    clk,
    input logic                    reset,
    trailing_zeros_expander_if.slave bus
);
    localparam int DIN_W = $clog2(DATA_WIDTH) + 1;
    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [DIN_W-1:0] FULL_COUNT = DIN_W'(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [IDX_W-1:0]      r_idx;
    logic [DIN_W-1:0]      r_count;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_word;
    logic [DATA_WIDTH-1:0] r_dout;

    logic                  w_accept;
    logic                  w_lastBit;
    logic                  w_bit;
    logic [DATA_WIDTH-1:0] w_wordNext;
    logic                  w_dinReady;
    logic                  w_bitValid;
    logic                  w_bitOut;
    logic                  w_doutValid;
    logic                  w_err;
    logic                  w_overflow;
    logic [DIN_W-1:0]      w_clamped;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_dinReady  = 1'b0;
        w_bitValid  = 1'b0;
        w_bitOut    = 1'b0;
        w_doutValid = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                w_dinReady = 1'b1;
                if (bus.din_valid) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                w_bitValid = 1'b1;
                w_bitOut   = w_bit;
                if (w_lastBit) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_doutValid = 1'b1;
                w_err       = r_ovf;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // A count of DATA_WIDTH never matches an index, so the stream stays all zero.
    assign w_bit      = ({1'b0, r_idx} == r_count);
    assign w_lastBit  = (r_idx == LAST_IDX);
    assign w_accept   = w_dinReady && bus.din_valid;
    assign w_overflow = (bus.din > FULL_COUNT);
    assign w_clamped  = w_overflow ? FULL_COUNT : bus.din;

    always_comb begin
        w_wordNext        = r_word;
        w_wordNext[r_idx] = w_bit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_word  <= '0;
            r_dout  <= '0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_count <= w_clamped;
            r_ovf   <= w_overflow;
            r_word  <= '0;
        end else if (r_state == SHIFT) begin
            r_word <= w_wordNext;
            if (w_lastBit) begin
                r_idx  <= '0;
                r_dout <= w_wordNext;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign bus.din_ready  = w_dinReady;
    assign bus.bit_out    = w_bitOut;
    assign bus.bit_valid  = w_bitValid;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = w_doutValid;
    assign bus.err        = w_err;
endmodule

// File: tb/tb_trailing_zeros_expander.sv
// Self-checking bench for the trailing-zeros expander at DATA_WIDTH=8: directed
// vectors, back-to-back, reset abort, then randomized traffic against a model.
module tb_trailing_zeros_expander;
    localparam int DW = 8;

    typedef struct {
        logic [3:0]    din;
        logic [DW-1:0] expWord;
        logic          expErr;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   passCount  = 0;

    trailing_zeros_expander_if #(.DATA_WIDTH(DW)) bus ();

    trailing_zeros_expander #(.DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endfunction

    function automatic int clampCount(input int d);
        return (d > DW) ? DW : d;
    endfunction

    function automatic logic [DW-1:0] expectedWord(input int d);
        logic [DW-1:0] w;
        int c;
        c = clampCount(d);
        w = '0;
        if (c < DW) w[c] = 1'b1;
        return w;
    endfunction

    function automatic int trailingZeros(input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) begin
            if (w[i]) return i;
        end
        return DW;
    endfunction

    task automatic applyStimulus(input logic [3:0] d, input logic v);
        bus.din       = d;
        bus.din_valid = v;
    endtask

    // One accepted count followed cycle by cycle through SHIFT, DONE and back to IDLE.
    task automatic runVector(input vec_t v);
        int c;
        c = clampCount(int'(v.din));
        @(negedge clk);
        checkOutput($sformatf("din%0d_ready_idle", v.din), bus.din_ready, 1);
        applyStimulus(v.din, 1'b1);
        @(negedge clk);
        applyStimulus(4'd0, 1'b0);
        for (int i = 0; i < DW; i++) begin
            checkOutput($sformatf("din%0d_bit_valid[%0d]", v.din, i), bus.bit_valid, 1);
            checkOutput($sformatf("din%0d_bit_out[%0d]", v.din, i), bus.bit_out, (i == c));
            checkOutput($sformatf("din%0d_ready_shift[%0d]", v.din, i), bus.din_ready, 0);
            checkOutput($sformatf("din%0d_dvalid_shift[%0d]", v.din, i), bus.dout_valid, 0);
            @(negedge clk);
        end
        checkOutput($sformatf("din%0d_dout_valid", v.din), bus.dout_valid, 1);
        checkOutput($sformatf("din%0d_dout", v.din), bus.dout, v.expWord);
        checkOutput($sformatf("din%0d_err", v.din), bus.err, v.expErr);
        checkOutput($sformatf("din%0d_bit_valid_done", v.din), bus.bit_valid, 0);
        checkOutput($sformatf("din%0d_ready_done", v.din), bus.din_ready, 0);
        checkOutput($sformatf("din%0d_roundtrip", v.din), trailingZeros(bus.dout), c);
        @(negedge clk);
        checkOutput($sformatf("din%0d_ready_back", v.din), bus.din_ready, 1);
        checkOutput($sformatf("din%0d_dvalid_after", v.din), bus.dout_valid, 0);
        checkOutput($sformatf("din%0d_err_after", v.din), bus.err, 0);
        checkOutput($sformatf("din%0d_dout_hold", v.din), bus.dout, v.expWord);
    endtask

    initial begin
        vec_t           vecs[7];
        int             acceptAt[2];
        int             nAcc;
        int             readyLow;
        logic [DW-1:0]  doutSeen[$];
        int             expQ[$];
        int             accepted;
        int             cyc;
        int             bitCnt;
        int             d;
        logic [DW-1:0]  bitStream;
        logic [3:0]     rd;
        logic           rv;

        vecs[0] = '{4'd3,  8'h08, 1'b0};
        vecs[1] = '{4'd0,  8'h01, 1'b0};
        vecs[2] = '{4'd8,  8'h00, 1'b0};
        vecs[3] = '{4'd12, 8'h00, 1'b1};
        vecs[4] = '{4'd7,  8'h80, 1'b0};
        vecs[5] = '{4'd15, 8'h00, 1'b1};
        vecs[6] = '{4'd1,  8'h02, 1'b0};

        // Reset with a valid input presented: it must not be taken.
        reset = 1'b1;
        applyStimulus(4'd5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_din_ready", bus.din_ready, 1);
        checkOutput("reset_bit_valid", bus.bit_valid, 0);
        checkOutput("reset_bit_out", bus.bit_out, 0);
        checkOutput("reset_dout", bus.dout, 0);
        checkOutput("reset_dout_valid", bus.dout_valid, 0);
        checkOutput("reset_err", bus.err, 0);
        reset = 1'b0;
        applyStimulus(4'd0, 1'b0);
        @(negedge clk);
        checkOutput("post_reset_no_accept", bus.bit_valid, 0);

        for (int k = 0; k < 7; k++) begin
            runVector(vecs[k]);
        end

        // Back-to-back: din_valid held high, din=7 then din=2.
        @(negedge clk);
        applyStimulus(4'd7, 1'b1);
        nAcc = 0;
        readyLow = 0;
        acceptAt[0] = 0;
        acceptAt[1] = 0;
        for (int n = 0; n < 24; n++) begin
            if (nAcc == 1) bus.din = 4'd2;
            if (nAcc == 2) bus.din_valid = 1'b0;
            if (bus.dout_valid) doutSeen.push_back(bus.dout);
            if (bus.din_ready && bus.din_valid) begin
                if (nAcc < 2) acceptAt[nAcc] = n;
                nAcc++;
            end else if (nAcc == 1 && !bus.din_ready) begin
                readyLow++;
            end
            @(negedge clk);
        end
        applyStimulus(4'd0, 1'b0);
        checkOutput("b2b_accepts", nAcc, 2);
        checkOutput("b2b_spacing", acceptAt[1] - acceptAt[0], DW + 2);
        checkOutput("b2b_ready_low", readyLow, DW + 1);
        checkOutput("b2b_dout_count", doutSeen.size(), 2);
        if (doutSeen.size() == 2) begin
            checkOutput("b2b_dout0", doutSeen[0], 8'h80);
            checkOutput("b2b_dout1", doutSeen[1], 8'h04);
        end

        // Reset in the 4th SHIFT cycle of din=5 aborts the word.
        @(negedge clk);
        applyStimulus(4'd5, 1'b1);
        @(negedge clk);
        applyStimulus(4'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_in_shift", bus.bit_valid, 1);
        reset = 1'b1;
        applyStimulus(4'd5, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'd0, 1'b0);
        checkOutput("abort_ready", bus.din_ready, 1);
        checkOutput("abort_bit_valid", bus.bit_valid, 0);
        checkOutput("abort_dout", bus.dout, 0);
        checkOutput("abort_dout_valid", bus.dout_valid, 0);
        nAcc = 0;
        for (int n = 0; n < 2 * DW; n++) begin
            @(negedge clk);
            if (bus.dout_valid || bus.bit_valid) nAcc++;
        end
        checkOutput("abort_quiet", nAcc, 0);

        // Randomized traffic with gaps; din_valid while busy must be ignored.
        accepted = 0;
        cyc = 0;
        bitCnt = 0;
        bitStream = '0;
        while (cyc < 40000 && (accepted < 1000 || expQ.size() != 0)) begin
            @(negedge clk);
            cyc++;
            if (bus.bit_valid) begin
                if (bitCnt < DW) bitStream[bitCnt] = bus.bit_out;
                bitCnt++;
            end else begin
                checkOutput("rand_bit_out_idle", bus.bit_out, 0);
            end
            if (bus.dout_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("rand_unexpected_dout", 1, 0);
                end else begin
                    d = expQ.pop_front();
                    checkOutput($sformatf("rand_dout_din%0d", d), bus.dout, expectedWord(d));
                    checkOutput($sformatf("rand_err_din%0d", d), bus.err, (d > DW));
                    checkOutput($sformatf("rand_roundtrip_din%0d", d), trailingZeros(bus.dout), clampCount(d));
                    checkOutput($sformatf("rand_stream_din%0d", d), bitStream, expectedWord(d));
                    checkOutput($sformatf("rand_bitcount_din%0d", d), bitCnt, DW);
                end
                bitCnt = 0;
                bitStream = '0;
            end else begin
                checkOutput("rand_err_idle", bus.err, 0);
            end
            if (accepted < 1000) begin
                rd = 4'($urandom_range(0, 15));
                rv = ($urandom_range(0, 3) != 0);
                applyStimulus(rd, rv);
                if (rv && bus.din_ready) begin
                    expQ.push_back(int'(rd));
                    accepted++;
                end
            end else begin
                applyStimulus(4'd0, 1'b0);
            end
        end
        checkOutput("rand_complete", (accepted == 1000 && expQ.size() == 0), 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/trailing_zeros_expander.md
TRAILING_ZEROS_EXPANDER -- requirements
Module: trailing_zeros_expander

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the reconstructed word width; legal values are 2 and above.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset; synchronous, active-high.
REQ-004 din  input  $clog2(DATA_WIDTH)+1  trailing-zero count to expand.
REQ-005 din_valid  input  1  din is valid this cycle.
REQ-006 din_ready  output  1  block can accept din this cycle.
REQ-007 bit_out  output  1  serial expanded bit, LSB first.
REQ-008 bit_valid  output  1  bit_out is valid this cycle.
REQ-009 dout  output  DATA_WIDTH  reconstructed word.
REQ-010 dout_valid  output  1  one-cycle pulse when dout is updated.
REQ-011 err  output  1  count out of range; valid only with dout_valid.

Function
REQ-012 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-013 din_ready SHALL be 1 in IDLE and 0 in SHIFT and DONE.
REQ-014 A transfer SHALL occur when din_valid and din_ready are both 1; in that cycle the block SHALL capture din and move to SHIFT.
REQ-015 Clamping rule: the effective count c = min(din, DATA_WIDTH); the overflow flag = (din > DATA_WIDTH); both SHALL be latched at accept.
REQ-016 SHIFT SHALL last exactly DATA_WIDTH cycles, indexed i = 0..DATA_WIDTH-1.
REQ-017 In each SHIFT cycle, bit_valid SHALL be 1 and bit_out SHALL be (i == c).
REQ-018 If c == DATA_WIDTH, all emitted bits SHALL be 0.
REQ-019 The index counter SHALL be at least $clog2(DATA_WIDTH) bits wide; SHIFT SHALL exit to DONE after i = DATA_WIDTH-1, with no wrap-around emission.
REQ-020 The reconstructed word SHALL be assembled from the emitted bits, with bit i at position i.
REQ-021 The assembled word SHALL equal (c < DATA_WIDTH) ? (1 << c) : 0.
REQ-022 DONE SHALL last one cycle: dout SHALL present the assembled word, dout_valid = 1, err = latched overflow flag; the next state SHALL be IDLE.
REQ-023 dout SHALL hold its value until the next DONE cycle.
REQ-024 dout_valid and err SHALL be 0 outside DONE.
REQ-025 bit_valid SHALL be 0, and bit_out SHALL be 0, outside SHIFT.
REQ-026 Latency: for an accept in cycle t, bits SHALL appear in cycles t+1..t+DATA_WIDTH, dout_valid in cycle t+DATA_WIDTH+1, and din_ready again in cycle t+DATA_WIDTH+2.
REQ-027 Back-to-back operation: with din_valid held at 1, a new accept SHALL occur in the first IDLE cycle, giving a throughput of one word per DATA_WIDTH+2 cycles.
REQ-028 Round-trip property: the trailing-zero count of dout (DATA_WIDTH if dout is all zeros) SHALL equal c.
REQ-029 din_valid while not ready SHALL be ignored; the stall is the source's responsibility.

Reset
REQ-030 While reset is 1 at a clock edge, the state SHALL become IDLE, the counters and latched values SHALL clear, and the outputs SHALL be: din_ready=1, bit_out=0, bit_valid=0, dout=0, dout_valid=0, err=0.
REQ-031 Reset in SHIFT or DONE SHALL abort the operation: no further bit_valid and no dout_valid for the aborted count.
REQ-032 An input presented in the reset cycle SHALL NOT be accepted.

Verification (DATA_WIDTH=8, din 4 bits)
REQ-033 din=3 accepted -> bits 0,0,0,1,0,0,0,0 over 8 cycles; then dout=8'h08, dout_valid=1, err=0.
REQ-034 din=0 -> first bit 1, remaining 7 bits 0; dout=8'h01.
REQ-035 din=8 -> 8 zero bits; dout=8'h00, err=0. din=12 -> 8 zero bits; dout=8'h00, err=1.
REQ-036 din_valid held 1 with din=7 then din=2 -> accepts 10 cycles apart; dout=8'h80, then 8'h04; din_ready=0 throughout each SHIFT and DONE.
REQ-037 reset asserted at the 4th SHIFT cycle of din=5 -> next cycle in IDLE with din_ready=1; no dout_valid; dout=0.
REQ-038 Random din 0..15 with random din_valid gaps (1000 transfers) -> every dout matches REQ-021, err matches din>8, and the round-trip property of REQ-028 holds.
